// File: rtl/dmem_rsp_pkg.sv
// dmem_rsp_pkg: shared types and constants for the data-memory responder.
package dmem_rsp_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wait-state counter width (LATENCY up to 15)
  localparam int unsigned CNT_W = 4;

  // Byte lanes per 32-bit word
  localparam int unsigned LANES = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle for the data-memory port.
// master = initiator (core side), slave = responder (memory side).
interface dmem_responder_if;
  import dmem_rsp_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [31:0]      req_addr;
  logic [LANES-1:0] req_be;
  logic [31:0]      req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_rsp_array.sv
// dmem_rsp_array: DEPTH_WORDS x 32 storage, synchronous per-lane write,
// registered read. Storage itself is not reset; only the read register is.
module dmem_rsp_array
  import dmem_rsp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [LANES-1:0] be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_q;

  // Byte-lane write into the selected word
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read; holds its value until the next read strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else if (re) rd_q <= mem[addr];
  end

  assign rdata = rd_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory responder with programmable wait
// states, byte-lane writes and out-of-range faulting.
// Optional feature macro: DMEM_RSP_ALIGN_CHECK_EN (fault misaligned addresses
// and zero byte-enable accesses).
module dmem_responder
  import dmem_rsp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [LANES-1:0] be_q;
  logic [31:0]      wdata_q;
  logic             rsp_err_q;
  logic             rsp_load_q;

  logic             accept;
  logic             commit;
  logic             cur_we;
  logic [31:0]      cur_addr;
  logic [LANES-1:0] cur_be;
  logic [31:0]      cur_wdata;
  logic [31:0]      offset;
  logic             fault;
  logic             arr_we;
  logic             arr_re;
  logic [31:0]      arr_rdata;

  assign accept = (state_q == IDLE) && bus.req_valid;

  // With zero latency the commit happens on the acceptance edge itself, so the
  // request fields come straight from the bus instead of the capture registers.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_be    = be_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_be    = bus.req_be;
      cur_wdata = bus.req_wdata;
    end
  end

  // Commit point: the edge that enters RESP
  assign commit = (accept && (LATENCY == 0)) ||
                  ((state_q == WAIT) && (cnt_q == CNT_W'(1)));

  // Range / fault decode; the subtraction wraps below BASE_ADDR to a huge index
  always_comb begin
    offset = cur_addr - BASE_ADDR;
    fault  = (offset >> 2) >= DEPTH_LIM;
`ifdef DMEM_RSP_ALIGN_CHECK_EN
    if ((cur_addr[1:0] != 2'b00) || (cur_be == '0)) fault = 1'b1;
`endif
  end

  assign arr_we = commit && cur_we && !fault;
  assign arr_re = commit && !cur_we && !fault;

  dmem_rsp_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (offset[AW+1:2]),
    .be    (cur_be),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  // Request capture, wait-state counting and response handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          we_q    <= bus.req_we;
          addr_q  <= bus.req_addr;
          be_q    <= bus.req_be;
          wdata_q <= bus.req_wdata;
          cnt_q   <= CNT_W'(LATENCY);
          state_q <= (LATENCY > 0) ? WAIT : RESP;
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= RESP;
        end
        RESP: if (bus.rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Response status registered at the commit edge, held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else if (commit) begin
      rsp_err_q  <= fault;
      rsp_load_q <= !cur_we && !fault;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_load_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned LAT   = 2;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete transaction; lat counts cycles from the acceptance cycle
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat, output logic ok);
    int n;
    ok = 1'b1; rdata = '0; err = 1'b0; lat = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_be = be; bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin ok = 1'b0; bus.req_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!bus.rsp_valid) begin ok = 1'b0; return; end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    tests++; if (bus.rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); end
    tests++; if (bus.rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat; logic ok;
    do_txn(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, rd, er, lat, ok);
    tests++; if (!ok) begin fails++; $display("FAIL store_timeout got timeout want response"); end
    tests++; if (lat != 3) begin fails++; $display("FAIL store_latency got %0d want 3", lat); end
    tests++; if (er !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL store_rsp got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    do_txn(1'b0, BASE + 32'h10, 4'hF, 32'h0, rd, er, lat, ok);
    tests++; if (!ok) begin fails++; $display("FAIL load_timeout got timeout want response"); end
    tests++; if (lat != 3) begin fails++; $display("FAIL load_latency got %0d want 3", lat); end
    tests++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin fails++; $display("FAIL load_data got %h err=%b want deadbeef err=0", rd, er); end
  endtask

  task automatic test_byte_lane();
    logic [31:0] rd; logic er; int lat; logic ok;
    do_txn(1'b1, BASE + 32'h20, 4'hF, 32'h1122_3344, rd, er, lat, ok);
    do_txn(1'b1, BASE + 32'h20, 4'b0010, 32'h0000_AA00, rd, er, lat, ok);
    do_txn(1'b0, BASE + 32'h20, 4'b0001, 32'h0, rd, er, lat, ok);
    tests++; if (rd !== 32'h1122_AA44 || er !== 1'b0) begin fails++; $display("FAIL byte_lane got %h err=%b want 1122aa44 err=0", rd, er); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat; logic ok;
    logic [31:0] top_addr;
    top_addr = BASE + DEPTH * 4 - 4;
    do_txn(1'b1, BASE, 4'hF, 32'hA5A5_A5A5, rd, er, lat, ok);
    do_txn(1'b1, top_addr, 4'hF, 32'h5A5A_5A5A, rd, er, lat, ok);
    do_txn(1'b0, BASE + DEPTH * 4, 4'hF, 32'h0, rd, er, lat, ok);
    tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL oor_load_high got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    do_txn(1'b0, BASE - 4, 4'hF, 32'h0, rd, er, lat, ok);
    tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL oor_load_low got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    do_txn(1'b1, BASE + DEPTH * 4, 4'hF, 32'hFFFF_FFFF, rd, er, lat, ok);
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL oor_store_high got err=%b want 1", er); end
    do_txn(1'b1, BASE - 4, 4'hF, 32'hFFFF_FFFF, rd, er, lat, ok);
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL oor_store_low got err=%b want 1", er); end
    do_txn(1'b0, BASE, 4'hF, 32'h0, rd, er, lat, ok);
    tests++; if (rd !== 32'hA5A5_A5A5) begin fails++; $display("FAIL oor_word0_intact got %h want a5a5a5a5", rd); end
    do_txn(1'b0, top_addr, 4'hF, 32'h0, rd, er, lat, ok);
    tests++; if (rd !== 32'h5A5A_5A5A) begin fails++; $display("FAIL oor_lastword_intact got %h want 5a5a5a5a", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; logic ok; int n; int bad;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = BASE + 32'h10;
    bus.req_be = 4'hF; bus.req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
    tests++; if (!bus.rsp_valid) begin fails++; $display("FAIL bp_timeout got rsp_valid=0 want 1"); end
    // a competing store must not be accepted while the response is pending
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_wdata = 32'h0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_BEEF ||
          bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle %0d got valid=%b rdata=%h err=%b req_ready=%b want 1/deadbeef/0/0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
      end
    end
    tests++; if (bad != 0) fails++;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    tests++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release got req_ready=%b rsp_valid=%b want 1/0", bus.req_ready, bus.rsp_valid); end
    do_txn(1'b0, BASE + 32'h10, 4'hF, 32'h0, rd, er, lat, ok);
    tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bp_no_accept got %h want deadbeef", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; logic ok; int bad;
    do_txn(1'b1, BASE + 32'h30, 4'hF, 32'h0, rd, er, lat, ok);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = BASE + 32'h30;
    bus.req_be = 4'hF; bus.req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        bad++;
        $display("FAIL rst_mid_state cycle %0d got rsp_valid=%b req_ready=%b want 0/1", i, bus.rsp_valid, bus.req_ready);
      end
      @(negedge clk);
    end
    tests++; if (bad != 0) fails++;
    do_txn(1'b0, BASE + 32'h30, 4'hF, 32'h0, rd, er, lat, ok);
    tests++; if (rd !== 32'h0 || er !== 1'b0) begin fails++; $display("FAIL rst_mid_dropped got %h err=%b want 0 err=0", rd, er); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat; logic ok;
    do_txn(1'b1, BASE + 32'h40, 4'hF, 32'h0102_0304, rd, er, lat, ok);
    do_txn(1'b1, BASE + 32'h42, 4'hF, 32'h9988_7766, rd, er, lat, ok);
`ifdef DMEM_RSP_ALIGN_CHECK_EN
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL misalign_err got %b want 1", er); end
    do_txn(1'b0, BASE + 32'h40, 4'hF, 32'h0, rd, er, lat, ok);
    tests++; if (rd !== 32'h0102_0304) begin fails++; $display("FAIL misalign_word got %h want 01020304", rd); end
    do_txn(1'b1, BASE + 32'h40, 4'h0, 32'hFFFF_FFFF, rd, er, lat, ok);
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL be0_store_err got %b want 1", er); end
`else
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL misalign_err got %b want 0", er); end
    do_txn(1'b0, BASE + 32'h40, 4'hF, 32'h0, rd, er, lat, ok);
    tests++; if (rd !== 32'h9988_7766) begin fails++; $display("FAIL misalign_word got %h want 99887766", rd); end
    do_txn(1'b1, BASE + 32'h40, 4'h0, 32'hFFFF_FFFF, rd, er, lat, ok);
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL be0_store_err got %b want 0", er); end
    do_txn(1'b0, BASE + 32'h40, 4'hF, 32'h0, rd, er, lat, ok);
    tests++; if (rd !== 32'h9988_7766) begin fails++; $display("FAIL be0_store_nowrite got %h want 99887766", rd); end
`endif
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_be = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_byte_lane();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_misaligned();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port: accepts one load or store request at a time over a valid/ready request channel, holds it for a programmable number of wait states, then returns a response (read data or write acknowledge) over a valid/ready response channel. It replaces the zero-latency combinational data memory when the core, or any other initiator, runs against a handshaked bus. It owns the word-organised storage array, supports byte-lane writes, and flags out-of-range accesses.

## Interface
- DEPTH_WORDS, 1024: storage size in 32-bit words; power of two, 16..65536.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to DEPTH_WORDS*4.
- LATENCY, 2: wait-state cycles between acceptance and response; 0..15.

- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_be  in  4  byte enables, bit i = byte lane i (bits [8i+7:8i]).
- req_wdata  in  32  store data, lane-aligned.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator accepts response.
- rsp_rdata  out  32  load data; 0 for stores and errored accesses.
- rsp_err  out  1  access faulted; qualified by rsp_valid.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture we/addr/be/wdata and load the wait counter with LATENCY. Go to WAIT if LATENCY>0, else RESP.
- WAIT: req_ready=0. Decrement the counter each cycle. Go to RESP on the edge where the counter reaches 0.
- On entry to RESP (the same edge): compute the index as (addr-BASE_ADDR)>>2. Out of range when index >= DEPTH_WORDS, with unsigned wrap-around treated as out of range.
  - In-range store: write the enabled lanes only.
  - In-range load: register the whole word into rsp_rdata. req_be does not mask read data.
  - Out of range: no write, rsp_rdata=0, rsp_err=1.
- RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_valid&&rsp_ready. Return to IDLE on that edge.
- rsp_ready is ignored outside RESP. req_valid is ignored outside IDLE, with no queueing.
- Store with req_be=4'b0000: no write; response is normal with rsp_err=0 (unless the macro below is enabled).
- Storage is not reset and powers up undefined.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0.
- Latency from acceptance edge to first rsp_valid=1 cycle is LATENCY+1 cycles.
- Minimum per-transaction period is LATENCY+2 cycles: req_ready returns the cycle after the response handshake.
- A store is committed exactly once, at the edge entering RESP. A load returns array contents as of that edge.
- Reset asserted mid-transaction aborts it:
  - A store not yet committed is dropped.
  - A store already committed remains in the array.
  - No response is issued after reset.
- req_ready depends only on state, not on req_valid (no combinational path from req_valid).

## Configuration
- DMEM_RSP_ALIGN_CHECK_EN defined:
  - In-range accesses with req_addr[1:0]!=0 are faulted: rsp_err=1, no write, rsp_rdata=0.
  - Stores with req_be=4'b0000 are faulted the same way.
  - Loads with req_be=0 are faulted the same way.
- Not defined: req_addr[1:0] is ignored (the word is selected by [31:2]), and only out-of-range accesses raise rsp_err.

## Structure
- Package dmem_rsp_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - the counter width constant (4 bits);
  - the byte-lane count (4).
- Sub-module dmem_rsp_array: DEPTH_WORDS×32 storage with a synchronous per-lane write and a registered read. The FSM, range check, and response registers stay in dmem_responder.

## Test plan
- Reset, then store 0xDEADBEEF to BASE_ADDR+0x10 with be=4'hF, then load the same address; LATENCY=2 → each rsp_valid first seen 3 cycles after acceptance; load returns 0xDEADBEEF; rsp_err=0.
- Store 0x0000AA00 with be=4'b0010 over a word holding 0x11223344, then load → 0x1122AA44.
- Load from BASE_ADDR+DEPTH_WORDS*4, and from BASE_ADDR-4 → rsp_err=1, rsp_rdata=0; no array word changes.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0; req_valid driven meanwhile is not accepted.
- Assert rst_n=0 during WAIT of a store of 0x12345678 to an address holding 0 → after reset rsp_valid=0 and req_ready=1; a subsequent load returns 0.
- With DMEM_RSP_ALIGN_CHECK_EN, store to BASE_ADDR+0x2 → rsp_err=1 and the word is unchanged. Without the macro, the same store writes word BASE_ADDR+0x0.
